// File: rtl/adc_acq_ctrl_if.sv
// Register-side and generator/readout-side signals of the ADC acquisition sequencer.
// The sequencer itself connects through the slave modport.
interface adc_acq_ctrl_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   start;
    logic                   abort;
    logic [31:0]            cfg_divider;
    logic [COUNT_WIDTH-1:0] cfg_samples;
    logic                   trigger;
    logic                   sample_done;
    logic [31:0]            divider;
    logic                   busy;
    logic                   done;
    logic                   overrun;
    logic [COUNT_WIDTH-1:0] sample_count;

    modport slave (
        input  start, abort, cfg_divider, cfg_samples, trigger, sample_done,
        output divider, busy, done, overrun, sample_count
    );

    modport master (
        output start, abort, cfg_divider, cfg_samples, trigger, sample_done,
        input  divider, busy, done, overrun, sample_count
    );
endinterface

// File: rtl/adc_acq_ctrl.sv
// Acquisition sequencer: programs the trigger generator, counts triggers and
// conversions, stops after N samples or on abort, then drains the last conversion.
module adc_acq_ctrl #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    adc_acq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state, state_n;
    logic [31:0]            div_q, div_n;
    logic [COUNT_WIDTH-1:0] num_q, num_n;
    logic [COUNT_WIDTH-1:0] trig_cnt, trig_n;
    logic                   outstanding, out_n;
    logic [31:0]            divider_n;
    logic                   busy_n, done_n, ovr_n;
    logic [COUNT_WIDTH-1:0] cnt_n;
    logic                   last_trig;

    // Compare in COUNT_WIDTH+1 bits so the saturated count cannot alias num_q.
    assign last_trig = bus.trigger && (num_q != '0) &&
                       (({1'b0, trig_cnt} + 1'b1) == {1'b0, num_q});

    always_comb begin
        state_n   = state;
        div_n     = div_q;
        num_n     = num_q;
        trig_n    = trig_cnt;
        out_n     = outstanding;
        ovr_n     = bus.overrun;
        cnt_n     = bus.sample_count;
        divider_n = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort && bus.cfg_divider != '0) begin
                    div_n     = bus.cfg_divider;
                    num_n     = bus.cfg_samples;
                    trig_n    = '0;
                    cnt_n     = '0;
                    ovr_n     = 1'b0;
                    out_n     = 1'b0;
                    state_n   = RUN;
                    divider_n = bus.cfg_divider;
                    busy_n    = 1'b1;
                end
            end
            RUN: begin
                divider_n = div_q;
                busy_n    = 1'b1;
                if (bus.sample_done && bus.sample_count != CNT_MAX)
                    cnt_n = bus.sample_count + 1'b1;
                if (bus.trigger) begin
                    if (trig_cnt != CNT_MAX)
                        trig_n = trig_cnt + 1'b1;
                    if (outstanding && !bus.sample_done)
                        ovr_n = 1'b1;
                    out_n = 1'b1;
                end else if (bus.sample_done) begin
                    out_n = 1'b0;
                end
                if (bus.abort || last_trig) begin
                    state_n   = DRAIN;
                    divider_n = '0;
                end
            end
            DRAIN: begin
                busy_n = 1'b1;
                if (bus.sample_done && bus.sample_count != CNT_MAX)
                    cnt_n = bus.sample_count + 1'b1;
                if (!outstanding || bus.sample_done) begin
                    out_n   = 1'b0;
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            div_q            <= '0;
            num_q            <= '0;
            trig_cnt         <= '0;
            outstanding      <= 1'b0;
            bus.divider      <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.sample_count <= '0;
        end else begin
            state            <= state_n;
            div_q            <= div_n;
            num_q            <= num_n;
            trig_cnt         <= trig_n;
            outstanding      <= out_n;
            bus.divider      <= divider_n;
            bus.busy         <= busy_n;
            bus.done         <= done_n;
            bus.overrun      <= ovr_n;
            bus.sample_count <= cnt_n;
        end
    end
endmodule

// File: doc/adc_acq_ctrl.md
# adc_acq_ctrl

Acquisition sequencer for the ADC trigger generator. On a start command it programs the generator's `divider`, then counts the triggers issued and the conversions completed. It stops the generator after a configured number of samples or on abort, waits for the last conversion, and reports done, sample count and overrun. It sits between the register interface and the trigger generator / ADC readout.

## Interface
- `COUNT_WIDTH`, 32, width of the sample counters and of `cfg_samples`.
- `clk` in 1: system clock (125 MHz nominal).
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle start request.
- `abort` in 1: one-cycle abort request.
- `cfg_divider` in 32: trigger period in clocks, latched on an accepted start; 0 is invalid.
- `cfg_samples` in COUNT_WIDTH: number of triggers to issue, latched on an accepted start; 0 means continuous until abort.
- `trigger` in 1: one-cycle pulse from the trigger generator.
- `sample_done` in 1: one-cycle pulse from the ADC readout when a conversion completes.
- `divider` out 32: period driven to the trigger generator; 0 disables it.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle completion pulse.
- `overrun` out 1: sticky error flag; set when a trigger arrives while a conversion is outstanding.
- `sample_count` out COUNT_WIDTH: number of completed conversions in the current or last run.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. All outputs are registered.
- **Internal registers:**
  - `div_q` and `num_q`: latched configuration.
  - `trig_cnt`: triggers accepted this run.
  - `outstanding`: one bit, a conversion is in flight.
- **IDLE:**
  - `divider`=0.
  - `start`=1 with `abort`=0 and `cfg_divider`≠0: latch `div_q`/`num_q`, clear `trig_cnt`, `sample_count`, `overrun` and `outstanding`, go to RUN.
  - `start` with `cfg_divider`=0 is ignored.
  - `abort` alone is ignored.
  - `abort` and `start` in the same cycle: start is ignored.
- **RUN:**
  - `divider`=`div_q`.
  - On `trigger`: `trig_cnt`+1. If `outstanding`=1 and `sample_done`=0 in the same cycle, set `overrun`. `outstanding` ends the cycle at 1.
  - On `sample_done` without `trigger`: clear `outstanding`.
  - `sample_done` always increments `sample_count`, in any state except IDLE and DONE.
  - When `num_q`≠0 and `trig_cnt`+`trigger` reaches `num_q`: go to DRAIN. The completing trigger is still counted.
  - `abort`: go to DRAIN. A trigger arriving in the abort cycle is still counted.
  - `start` in RUN is ignored.
- **DRAIN:**
  - `divider`=0.
  - `trigger` pulses are ignored: not counted, no overrun.
  - Stay while `outstanding`=1 and `sample_done`=0; otherwise go to DONE.
- **DONE:** `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- **After a run:** `sample_count` and `overrun` hold their values until the next accepted start.
- **Counters:** saturate at all-ones in continuous mode; they do not wrap.
- **Reset:** `resetn` low, including mid-run, asynchronously forces IDLE with all outputs 0. The generator is therefore disabled immediately.

## Timing
- **Reset values:** `divider`=0, `busy`=0, `done`=0, `overrun`=0, `sample_count`=0.
- **Start latency:** `start` sampled at edge N gives `busy`=1 and `divider`=`cfg_divider` after edge N.
- **Stop latency:** the final trigger (or `abort`) sampled at edge T gives `divider`=0 after edge T.
- **Completion latency:** DRAIN exits on the edge that samples `sample_done`, or on the first DRAIN edge if `outstanding`=0. `done`=1 and `busy`=0 after that edge; `done` drops after the next edge.
- **Status update:** `overrun` and `sample_count` update one cycle after the sampled pulse.
- **Simultaneous `trigger` and `sample_done`:** no overrun; `sample_count`+1 and `trig_cnt`+1 in the same cycle.
- **Minimum supported pulse spacing:** back-to-back pulses (every cycle) on `trigger` and `sample_done`.

## Test plan
- **Reset:**
  - Stimulus: hold `resetn`=0 for 4 half-periods, then release.
  - Required: all outputs 0 throughout.
  - Stimulus: pulse `trigger`/`sample_done` while in IDLE.
  - Required: no change on any output.
- **Normal run:**
  - Stimulus: `cfg_divider`=10, `cfg_samples`=4; model the generator as a trigger every 10 cycles and `sample_done` 3 cycles after each trigger.
  - Required: `divider`=10 one cycle after `start`; `divider`=0 one cycle after the 4th trigger; `done` pulses once; `sample_count`=4, `overrun`=0.
- **Overrun:**
  - Stimulus: same configuration, but withhold `sample_done` until after the 2nd trigger.
  - Required: `overrun`=1 one cycle after the 2nd trigger; it stays 1 after `done`.
  - Stimulus: issue a new start.
  - Required: `overrun` cleared.
- **Continuous mode with abort:**
  - Stimulus: `cfg_samples`=0; `abort` after 2 completed samples with a 3rd conversion in flight.
  - Required: `divider`=0 next cycle; `done` one cycle after the 3rd `sample_done`; `sample_count`=3.
- **Ignored commands:**
  - Stimulus: `start` with `cfg_divider`=0.
  - Required: stays IDLE.
  - Stimulus: `start` while in RUN.
  - Required: latched configuration unchanged.
  - Stimulus: a `trigger` pulse in DRAIN.
  - Required: not counted, no overrun.
- **Async reset mid-RUN and coincident pulses:**
  - Stimulus: drop `resetn` while in RUN.
  - Required: `divider` and `busy` go to 0 before the next clock edge.
  - Stimulus: `trigger` and `sample_done` in the same cycle while `outstanding`=1.
  - Required: `overrun` stays 0.
